seq_detector_param: RTL

- Parametrised serial sequence detector; next generation of the team's fixed-pattern detector.
- Compares the last PAT_W valid input bits against a runtime-loadable pattern with a per-bit don't-care mask.
- Selectable overlapping or non-overlapping detection.
- Sits on a serial bit stream, qualified by a valid strobe, and emits a one-cycle match pulse.

---
 rtl/seq_detector_param.sv | 96 +++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with runtime pattern/mask and overlap select.
// Optional saturating match counter enabled by SEQ_DET_MATCH_CNT_EN.
module seq_detector_param #(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_INIT  = 4'b1101,
    parameter logic [PAT_W-1:0] MASK_INIT = '1,
    parameter logic             OVL_INIT  = 1'b1,
    parameter int               CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sequence_in,
    input  logic             i_valid,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [PAT_W-1:0] i_mask,
    input  logic             i_overlap_en,
    output logic             o_detector_out,
    output logic             o_armed,
    output logic [CNT_W-1:0] o_match_count
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d, mask_q, mask_d, hist_q, hist_d, new_hist;
    logic             ovl_q, ovl_d, det_q, det_d, match;
    logic [FW-1:0]    fill_q, fill_d, new_fill;

    always_comb begin
        pat_d    = pat_q;
        mask_d   = mask_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        det_d    = 1'b0;
        new_hist = {hist_q[PAT_W-2:0], i_sequence_in};
        new_fill = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        match    = (new_fill == FULL) && (((new_hist ^ pat_q) & mask_q) == '0) && (mask_q != '0);
        if (i_load) begin
            pat_d  = i_pattern;
            mask_d = i_mask;
            ovl_d  = i_overlap_en;
            hist_d = '0;
            fill_d = '0;
        end else if (i_valid) begin
            hist_d = new_hist;
            fill_d = (match && !ovl_q) ? '0 : new_fill;
            det_d  = match;
        end
        state_d = (fill_d == '0) ? EMPTY : (fill_d == FULL) ? ARMED : FILLING;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pat_q   <= PAT_INIT;
            mask_q  <= MASK_INIT;
            ovl_q   <= OVL_INIT;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
            state_q <= state_d;
        end
    end

    assign o_detector_out = det_q;
    assign o_armed        = (state_q == ARMED);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts alongside the pulse being set, saturating instead of wrapping.
    always_comb begin
        cnt_d = i_load ? '0 : (det_d && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_match_count = cnt_q;
`else
    assign o_match_count = '0;
`endif
endmodule
